dm_agu: RTL and testbench

//  Data-memory address generator and access sequencer. Consumes the 8-bit

---
 rtl/dm_agu.sv | 145 ++++++++++++++
 tb/tb_dm_agu.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/dm_agu.sv
// dm_agu: data-memory address generator and access sequencer.
// Issues one load or store to a synchronous data memory per accepted request.
// The address comes from the lookup table or from an internal pointer register.
// Ports:
//   Clk, Reset          clock and synchronous active-high reset
//   req_i, op_i         request strobe and opcode (00 LOAD, 01 STORE, 10 SETPTR, 11 reserved)
//   lut_i, use_ptr_i    table address/value, and a select for the pointer as address
//   inc_i               post-increment the pointer on a pointer-based access
//   wr_data_i           store data
//   mem_rdat_i          memory read data, valid one cycle after mem_ren_o
//   mem_adr_o, mem_ren_o, mem_wen_o, mem_wdat_o   registered memory interface
//   rd_data_o           last completed load data
//   ptr_o               pointer register
//   busy_o, done_o, err_o   status: busy, completion pulse, reserved-op pulse
module dm_agu #(
  parameter int unsigned AW      = 8,
  parameter int unsigned DW      = 8,
  parameter int unsigned STRIDE  = 1,
  parameter int unsigned PTR_RST = 0
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          req_i,
  input  logic [1:0]    op_i,
  input  logic [AW-1:0] lut_i,
  input  logic          use_ptr_i,
  input  logic          inc_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic [DW-1:0] mem_rdat_i,
  output logic [AW-1:0] mem_adr_o,
  output logic          mem_ren_o,
  output logic          mem_wen_o,
  output logic [DW-1:0] mem_wdat_o,
  output logic [DW-1:0] rd_data_o,
  output logic [AW-1:0] ptr_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_CAP  = 2'd2;
  localparam logic [1:0] S_WR   = 2'd3;

  localparam logic [1:0] OP_LOAD   = 2'b00;
  localparam logic [1:0] OP_STORE  = 2'b01;
  localparam logic [1:0] OP_SETPTR = 2'b10;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] adr_d;
  logic          ren_d, wen_d;
  logic [DW-1:0] wdat_d, rdat_d;
  logic          busy_d, done_d, err_d;
  logic [AW-1:0] addr;

  // Address is sampled with the pre-increment pointer value.
  assign addr  = use_ptr_i ? ptr_q : lut_i;
  assign ptr_o = ptr_q;

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    adr_d   = mem_adr_o;
    ren_d   = 1'b0;
    wen_d   = 1'b0;
    wdat_d  = mem_wdat_o;
    rdat_d  = rd_data_o;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          case (op_i)
            OP_LOAD: begin
              state_d = S_RD;
              ren_d   = 1'b1;
              adr_d   = addr;
              if (use_ptr_i && inc_i) ptr_d = ptr_q + AW'(STRIDE);
            end
            OP_STORE: begin
              state_d = S_WR;
              wen_d   = 1'b1;
              adr_d   = addr;
              wdat_d  = wr_data_i;
              if (use_ptr_i && inc_i) ptr_d = ptr_q + AW'(STRIDE);
            end
            OP_SETPTR: begin
              ptr_d  = lut_i;
              done_d = 1'b1;
            end
            default: begin
              done_d = 1'b1;
              err_d  = 1'b1;
            end
          endcase
        end
      end
      S_RD: state_d = S_CAP;
      S_CAP: begin
        state_d = S_IDLE;
        rdat_d  = mem_rdat_i;
        done_d  = 1'b1;
      end
      S_WR: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; reset aborts any operation in flight.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= AW'(PTR_RST);
      mem_adr_o  <= '0;
      mem_ren_o  <= 1'b0;
      mem_wen_o  <= 1'b0;
      mem_wdat_o <= '0;
      rd_data_o  <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      mem_adr_o  <= adr_d;
      mem_ren_o  <= ren_d;
      mem_wen_o  <= wen_d;
      mem_wdat_o <= wdat_d;
      rd_data_o  <= rdat_d;
      busy_o     <= busy_d;
      done_o     <= done_d;
      err_o      <= err_d;
    end
  end

endmodule

// File: tb/tb_dm_agu.sv
// tb_dm_agu: directed self-checking bench for dm_agu with a synchronous memory model.
module tb_dm_agu;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       req_i;
  logic [1:0] op_i;
  logic [7:0] lut_i;
  logic       use_ptr_i;
  logic       inc_i;
  logic [7:0] wr_data_i;
  logic [7:0] mem_rdat_i;
  logic [7:0] mem_adr_o;
  logic       mem_ren_o;
  logic       mem_wen_o;
  logic [7:0] mem_wdat_o;
  logic [7:0] rd_data_o;
  logic [7:0] ptr_o;
  logic       busy_o;
  logic       done_o;
  logic       err_o;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] mem [256];
  logic       init_done = 1'b0;

  dm_agu #(.AW(8), .DW(8), .STRIDE(1), .PTR_RST(0)) dut (
    .Clk(Clk), .Reset(Reset), .req_i(req_i), .op_i(op_i), .lut_i(lut_i),
    .use_ptr_i(use_ptr_i), .inc_i(inc_i), .wr_data_i(wr_data_i),
    .mem_rdat_i(mem_rdat_i), .mem_adr_o(mem_adr_o), .mem_ren_o(mem_ren_o),
    .mem_wen_o(mem_wen_o), .mem_wdat_o(mem_wdat_o), .rd_data_o(rd_data_o),
    .ptr_o(ptr_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 Clk = ~Clk;

  // Memory model: contents preset to addr ^ 0xC9 (so mem[0xF5] = 0x3C).
  always @(posedge Clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hC9;
      init_done  <= 1'b1;
      mem_rdat_i <= 8'h00;
    end else begin
      if (mem_ren_o) mem_rdat_i <= mem[mem_adr_o];
      if (mem_wen_o) mem[mem_adr_o] <= mem_wdat_o;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the edge.
  task automatic tick();
    @(posedge Clk);
    #1;
    chk("excl", 32'(mem_ren_o & mem_wen_o), 32'h0);
  endtask

  task automatic drive(input logic req, input logic [1:0] op, input logic [7:0] lut,
                       input logic up, input logic inc, input logic [7:0] wd);
    req_i = req; op_i = op; lut_i = lut; use_ptr_i = up; inc_i = inc; wr_data_i = wd;
  endtask

  initial begin
    // 1: reset held two cycles with inputs toggling
    Reset = 1'b1;
    drive(1'b1, 2'b10, 8'hAA, 1'b1, 1'b1, 8'h55);
    tick();
    drive(1'b1, 2'b00, 8'h55, 1'b0, 1'b1, 8'hAA);
    tick();
    chk("rst_adr",  32'(mem_adr_o),  32'h0);
    chk("rst_ren",  32'(mem_ren_o),  32'h0);
    chk("rst_wen",  32'(mem_wen_o),  32'h0);
    chk("rst_wdat", 32'(mem_wdat_o), 32'h0);
    chk("rst_rd",   32'(rd_data_o),  32'h0);
    chk("rst_ptr",  32'(ptr_o),      32'h0);
    chk("rst_busy", 32'(busy_o),     32'h0);
    chk("rst_done", 32'(done_o),     32'h0);
    chk("rst_err",  32'(err_o),      32'h0);
    Reset = 1'b0;
    drive(1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 8'h00);
    tick();

    // 2: LOAD from table address 0xF5
    drive(1'b1, 2'b00, 8'hF5, 1'b0, 1'b0, 8'h00);
    tick();
    drive(1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 8'h00);
    chk("ld_ren",   32'(mem_ren_o), 32'h1);
    chk("ld_adr",   32'(mem_adr_o), 32'hF5);
    chk("ld_busy1", 32'(busy_o),    32'h1);
    chk("ld_done0", 32'(done_o),    32'h0);
    tick();
    chk("ld_ren_off", 32'(mem_ren_o), 32'h0);
    chk("ld_busy2",   32'(busy_o),    32'h1);
    chk("ld_done1",   32'(done_o),    32'h0);
    tick();
    chk("ld_done",  32'(done_o),    32'h1);
    chk("ld_data",  32'(rd_data_o), 32'h3C);
    chk("ld_busy3", 32'(busy_o),    32'h0);
    chk("ld_adr_hold", 32'(mem_adr_o), 32'hF5);

    // 3: SETPTR 0xFF then back-to-back STORE via pointer with increment (wraps to 0)
    drive(1'b1, 2'b10, 8'hFF, 1'b0, 1'b0, 8'h00);
    tick();
    chk("sp_done", 32'(done_o),    32'h1);
    chk("sp_ptr",  32'(ptr_o),     32'hFF);
    chk("sp_ren",  32'(mem_ren_o), 32'h0);
    chk("sp_wen",  32'(mem_wen_o), 32'h0);
    chk("ld_done_pulse", 32'(rd_data_o), 32'h3C);
    drive(1'b1, 2'b01, 8'h12, 1'b1, 1'b1, 8'hA5);
    tick();
    drive(1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 8'h00);
    chk("st_wen",  32'(mem_wen_o),  32'h1);
    chk("st_adr",  32'(mem_adr_o),  32'hFF);
    chk("st_wdat", 32'(mem_wdat_o), 32'hA5);
    chk("st_ptr",  32'(ptr_o),      32'h00);
    chk("st_done0", 32'(done_o),    32'h0);
    chk("st_busy", 32'(busy_o),     32'h1);
    tick();
    chk("st_wen_off", 32'(mem_wen_o), 32'h0);
    chk("st_done",    32'(done_o),    32'h1);
    chk("st_busy0",   32'(busy_o),    32'h0);
    chk("st_mem",     32'(mem[255]),  32'hA5);

    // 4: LOAD via pointer (0x00 -> 0xC9) with a STORE held while busy
    drive(1'b1, 2'b00, 8'h33, 1'b1, 1'b0, 8'h00);
    tick();
    chk("ld2_adr", 32'(mem_adr_o), 32'h00);
    chk("ld2_ren", 32'(mem_ren_o), 32'h1);
    drive(1'b1, 2'b01, 8'h10, 1'b0, 1'b1, 8'h77);
    tick();
    chk("hold_wen1",  32'(mem_wen_o), 32'h0);
    chk("hold_busy1", 32'(busy_o),    32'h1);
    tick();
    chk("hold_wen2",  32'(mem_wen_o), 32'h0);
    chk("ld2_done",   32'(done_o),    32'h1);
    chk("ld2_data",   32'(rd_data_o), 32'hC9);
    tick();
    drive(1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 8'h00);
    chk("b2b_wen",  32'(mem_wen_o),  32'h1);
    chk("b2b_adr",  32'(mem_adr_o),  32'h10);
    chk("b2b_wdat", 32'(mem_wdat_o), 32'h77);
    chk("b2b_done0", 32'(done_o),    32'h0);
    chk("b2b_ptr",  32'(ptr_o),      32'h00);
    tick();
    chk("b2b_done", 32'(done_o), 32'h1);
    chk("b2b_mem",  32'(mem[16]), 32'h77);

    // 5: reset during CAP of a LOAD from 0x20
    drive(1'b1, 2'b00, 8'h20, 1'b0, 1'b0, 8'h00);
    tick();
    drive(1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 8'h00);
    tick();
    Reset = 1'b1;
    tick();
    chk("abt_done", 32'(done_o),    32'h0);
    chk("abt_rd",   32'(rd_data_o), 32'h0);
    chk("abt_busy", 32'(busy_o),    32'h0);
    chk("abt_ren",  32'(mem_ren_o), 32'h0);
    Reset = 1'b0;
    tick();
    chk("abt_done2", 32'(done_o),    32'h0);
    chk("abt_rd2",   32'(rd_data_o), 32'h0);
    chk("abt_busy2", 32'(busy_o),    32'h0);

    // 6: reserved opcode with a non-zero pointer
    drive(1'b1, 2'b10, 8'h42, 1'b0, 1'b0, 8'h00);
    tick();
    drive(1'b1, 2'b11, 8'h99, 1'b1, 1'b1, 8'hEE);
    tick();
    drive(1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 8'h00);
    chk("rsv_err",  32'(err_o),     32'h1);
    chk("rsv_done", 32'(done_o),    32'h1);
    chk("rsv_ren",  32'(mem_ren_o), 32'h0);
    chk("rsv_wen",  32'(mem_wen_o), 32'h0);
    chk("rsv_ptr",  32'(ptr_o),     32'h42);
    chk("rsv_busy", 32'(busy_o),    32'h0);
    tick();
    chk("rsv_err0",  32'(err_o),  32'h0);
    chk("rsv_done0", 32'(done_o), 32'h0);

    // Post-increment via LOAD and ignored increment without pointer select
    drive(1'b1, 2'b00, 8'h01, 1'b1, 1'b1, 8'h00);
    tick();
    drive(1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 8'h00);
    chk("inc_adr", 32'(mem_adr_o), 32'h42);
    chk("inc_ptr", 32'(ptr_o),     32'h43);
    tick();
    tick();
    chk("inc_data", 32'(rd_data_o), 32'h8B);
    drive(1'b1, 2'b00, 8'h07, 1'b0, 1'b1, 8'h00);
    tick();
    drive(1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 8'h00);
    chk("noinc_ptr", 32'(ptr_o),     32'h43);
    chk("noinc_adr", 32'(mem_adr_o), 32'h07);
    tick();
    tick();
    chk("noinc_data", 32'(rd_data_o), 32'hCE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
